ex_issue_ctrl: RTL and testbench

EX-stage sequencer that accepts one decoded instruction per cycle from ID and steers it to the combinational integer ALU or the multi-cycle multiply/divide unit (MDU). It owns the single-entry EX→MEM result register and the valid/ready handshakes on both sides. It also handles pipeline flush and an MDU watchdog. The ALU's operand and function fields are driven from this block.

---
 rtl/ex_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl.sv
// EX-stage issue sequencer: steers each accepted instruction to the ALU or the MDU
// and owns the single EX->MEM result register, flush handling and an MDU watchdog.
//
// state  | meaning
// S_IDLE | result register empty, ready for a new instruction
// S_MDU  | waiting on the MDU (watchdog counting)
// S_OUT  | result register valid, waiting for MEM to take it
module ex_issue_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [11:0] in_imm,
  input  logic [63:0] in_rs1_val,
  input  logic [63:0] in_rs2_val,
  input  logic [4:0]  in_rd,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [11:0] alu_immed,
  output logic [63:0] alu_reg1,
  output logic [63:0] alu_reg2,
  input  logic [63:0] alu_result,
  output logic        mdu_start,
  output logic        mdu_abort,
  output logic [63:0] mdu_a,
  output logic [63:0] mdu_b,
  output logic [2:0]  mdu_funct3,
  output logic        mdu_word,
  input  logic        mdu_done,
  input  logic [63:0] mdu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_MDU, S_OUT} state_t;

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_OPW   = 7'b0111011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMMW  = 7'b0011011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [63:0]       r_out_result;
  logic [4:0]        r_out_rd;
  logic              r_out_illegal;
  logic              r_mdu_start;
  logic              r_mdu_abort;
  logic              r_timeout;
  logic [63:0]       r_mdu_a;
  logic [63:0]       r_mdu_b;
  logic [2:0]        r_mdu_funct3;
  logic              r_mdu_word;
  logic [4:0]        r_mdu_rd;

  logic w_is_mdu;
  logic w_is_alu;
  logic w_accept;
  logic w_wd_fire;

  assign alu_opcode = in_opcode;
  assign alu_funct3 = in_funct3;
  assign alu_funct7 = in_funct7;
  assign alu_immed  = in_imm;
  assign alu_reg1   = in_rs1_val;
  assign alu_reg2   = in_rs2_val;

  assign w_is_mdu = ((in_opcode == OP_OP) || (in_opcode == OP_OPW)) && (in_funct7 == F7_MULDIV);
  assign w_is_alu = !w_is_mdu && ((in_opcode == OP_OP) || (in_opcode == OP_OPW) ||
                                  (in_opcode == OP_IMM) || (in_opcode == OP_IMMW));
  assign w_accept = in_valid && in_ready;
  // Watchdog fires on the last permitted S_MDU cycle only if done has not arrived.
  assign w_wd_fire = (r_state == S_MDU) && !mdu_done && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_is_mdu ? S_MDU : S_OUT;
        S_MDU:  if (mdu_done || w_wd_fire) w_next = S_OUT;
        S_OUT: begin
          if (out_ready) begin
            if (w_accept) w_next = w_is_mdu ? S_MDU : S_OUT;
            else          w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = !reset && !flush &&
                ((r_state == S_IDLE) || ((r_state == S_OUT) && out_ready));
    out_valid = (r_state == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_out_result  <= '0;
      r_out_rd      <= '0;
      r_out_illegal <= 1'b0;
      r_mdu_start   <= 1'b0;
      r_mdu_abort   <= 1'b0;
      r_timeout     <= 1'b0;
      r_mdu_a       <= '0;
      r_mdu_b       <= '0;
      r_mdu_funct3  <= '0;
      r_mdu_word    <= 1'b0;
      r_mdu_rd      <= '0;
    end else begin
      r_mdu_start <= 1'b0;
      r_mdu_abort <= 1'b0;
      if (flush) begin
        // Accept is blocked under flush, so an in-flight MDU op is the only thing to cancel.
        if (r_state == S_MDU) r_mdu_abort <= 1'b1;
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_is_mdu) begin
          r_mdu_a      <= in_rs1_val;
          r_mdu_b      <= in_rs2_val;
          r_mdu_funct3 <= in_funct3;
          r_mdu_word   <= (in_opcode == OP_OPW);
          r_mdu_rd     <= in_rd;
          r_mdu_start  <= 1'b1;
          r_cnt        <= '0;
        end else begin
          r_out_result  <= w_is_alu ? alu_result : 64'd0;
          r_out_rd      <= in_rd;
          r_out_illegal <= !w_is_alu;
        end
      end else if (r_state == S_MDU) begin
        if (mdu_done) begin
          r_out_result  <= mdu_result;
          r_out_rd      <= r_mdu_rd;
          r_out_illegal <= 1'b0;
        end else if (w_wd_fire) begin
          r_timeout     <= 1'b1;
          r_mdu_abort   <= 1'b1;
          r_out_result  <= 64'd0;
          r_out_rd      <= r_mdu_rd;
          r_out_illegal <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign mdu_start   = r_mdu_start;
  assign mdu_abort   = r_mdu_abort;
  assign mdu_a       = r_mdu_a;
  assign mdu_b       = r_mdu_b;
  assign mdu_funct3  = r_mdu_funct3;
  assign mdu_word    = r_mdu_word;
  assign out_result  = r_out_result;
  assign out_rd      = r_out_rd;
  assign out_illegal = r_out_illegal;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl; the bench plays a tiny ALU and the MDU.
module tb_ex_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [6:0]  in_opcode, in_funct7, alu_opcode, alu_funct7;
  logic [2:0]  in_funct3, alu_funct3, mdu_funct3;
  logic [11:0] in_imm, alu_immed;
  logic [63:0] in_rs1_val, in_rs2_val, alu_reg1, alu_reg2, alu_result;
  logic [4:0]  in_rd, out_rd;
  logic        mdu_start, mdu_abort, mdu_word, mdu_done;
  logic [63:0] mdu_a, mdu_b, mdu_result, out_result;
  logic        out_valid, out_ready, out_illegal, timeout_err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Bench ALU: ADDI, ADD, and an arbitrary nonzero pattern for anything else.
  assign alu_result = (alu_opcode == 7'b0010011) ? alu_reg1 + {{52{alu_immed[11]}}, alu_immed} :
                      (alu_opcode == 7'b0110011) ? alu_reg1 + alu_reg2 :
                      (alu_reg1 ^ alu_reg2 ^ 64'hA5);

  ex_issue_ctrl #(.MDU_TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rd(in_rd),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_immed(alu_immed), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_result(alu_result),
    .mdu_start(mdu_start), .mdu_abort(mdu_abort), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_funct3(mdu_funct3), .mdu_word(mdu_word), .mdu_done(mdu_done), .mdu_result(mdu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_illegal(out_illegal), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [11:0] imm, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_imm = imm; in_rs1_val = a; in_rs2_val = b; in_rd = rd;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_rd = '0;
    mdu_done = 1'b0; mdu_result = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // ADDI 5 + (-1)
    out_ready = 1'b1;
    drive(7'b0010011, 3'd0, 7'd0, 12'hFFF, 64'd5, 64'd0, 5'd1);
    #1;
    chk("alu_reg1_copy", alu_reg1, 64'd5);
    chk("alu_immed_copy", alu_immed, 64'hFFF);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_result", out_result, 64'd4);
    chk("addi_rd", out_rd, 64'd1);
    chk("addi_illegal", out_illegal, 0);
    chk("addi_in_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("addi_drain", out_valid, 0);

    // Back-to-back ADDs under backpressure
    out_ready = 1'b0;
    drive(7'b0110011, 3'd0, 7'd0, 12'd0, 64'd10, 64'd20, 5'd3);
    tick();
    drive(7'b0110011, 3'd0, 7'd0, 12'd0, 64'd100, 64'd1, 5'd4);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_result", out_result, 64'd30);
      chk("bp_hold_rd", out_rd, 64'd3);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_second_result", out_result, 64'd101);
    chk("bp_second_rd", out_rd, 64'd4);
    chk("bp_second_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();

    // MUL 6*7, MDU answers 5 cycles after start
    drive(7'b0110011, 3'd0, 7'b0000001, 12'd0, 64'd6, 64'd7, 5'd5);
    tick();
    in_valid = 1'b0;
    chk("mul_start", mdu_start, 1);
    chk("mul_a", mdu_a, 64'd6);
    chk("mul_b", mdu_b, 64'd7);
    chk("mul_word", mdu_word, 0);
    chk("mul_wait_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mul_start_once", mdu_start, 0);
      chk("mul_wait_ready", in_ready, 0);
    end
    mdu_done = 1'b1; mdu_result = 64'd42;
    tick();
    mdu_done = 1'b0;
    chk("mul_result", out_result, 64'd42);
    chk("mul_rd", out_rd, 64'd5);
    chk("mul_valid", out_valid, 1);
    tick();

    // MULW flushed in its second S_MDU cycle
    drive(7'b0111011, 3'd0, 7'b0000001, 12'd0, 64'd3, 64'd4, 5'd6);
    tick();
    chk("mulw_word", mdu_word, 1);
    drive(7'b0110011, 3'd0, 7'd0, 12'd0, 64'd1, 64'd1, 5'd9);
    tick();
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_abort", mdu_abort, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_next_ready", in_ready, 1);
    chk("flush_no_start", mdu_start, 0);
    tick();
    chk("flush_abort_once", mdu_abort, 0);
    mdu_done = 1'b1; mdu_result = 64'd99;
    tick();
    mdu_done = 1'b0;
    chk("stale_done_ignored", out_valid, 0);

    // Watchdog: MDU never completes
    drive(7'b0110011, 3'd0, 7'b0000001, 12'd0, 64'd2, 64'd2, 5'd7);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    chk("wd_not_yet", timeout_err, 0);
    chk("wd_not_yet_valid", out_valid, 0);
    tick();
    chk("wd_timeout", timeout_err, 1);
    chk("wd_abort", mdu_abort, 1);
    chk("wd_valid", out_valid, 1);
    chk("wd_result", out_result, 0);
    chk("wd_rd", out_rd, 64'd7);
    tick();
    chk("wd_abort_once", mdu_abort, 0);
    drive(7'b0010011, 3'd0, 7'd0, 12'd1, 64'd1, 64'd0, 5'd2);
    tick();
    in_valid = 1'b0;
    chk("wd_sticky", timeout_err, 1);
    chk("post_wd_addi", out_result, 64'd2);
    tick();

    // Illegal opcode
    drive(7'b1111111, 3'd0, 7'd0, 12'd0, 64'd1, 64'd2, 5'd8);
    tick();
    in_valid = 1'b0;
    chk("ill_flag", out_illegal, 1);
    chk("ill_result", out_result, 0);
    chk("ill_rd", out_rd, 64'd8);
    tick();

    // mdu_done in the same cycle as mdu_start
    drive(7'b0110011, 3'd4, 7'b0000001, 12'd0, 64'd77, 64'd1, 5'd10);
    tick();
    in_valid = 1'b0;
    mdu_done = 1'b1; mdu_result = 64'd77;
    tick();
    mdu_done = 1'b0;
    chk("fast_done_result", out_result, 64'd77);
    chk("fast_done_illegal", out_illegal, 0);
    tick();

    // Reset mid-MDU
    drive(7'b0111011, 3'd5, 7'b0000001, 12'd0, 64'd9, 64'd9, 5'd11);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_result", out_result, 0);
    chk("rst_mid_rd", out_rd, 0);
    chk("rst_mid_illegal", out_illegal, 0);
    chk("rst_mid_start", mdu_start, 0);
    chk("rst_mid_abort", mdu_abort, 0);
    chk("rst_mid_timeout", timeout_err, 0);
    chk("rst_mid_a", mdu_a, 0);
    chk("rst_mid_b", mdu_b, 0);
    chk("rst_mid_f3", mdu_funct3, 0);
    chk("rst_mid_word", mdu_word, 0);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
